// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. It validates the start bit at mid-bit and samples each data and stop bit at its centre.
// Received bytes leave on a valid/ready handshake, with one-cycle frame_err and overrun pulses.
module uart_rx #(
  parameter int N_CYCLES = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  // state | meaning
  // IDLE  | line idle, waiting for a falling edge on rxs
  // START | counting to mid start bit, then confirming it is still low
  // DATA  | sampling the 8 data bits at their centres
  // STOP  | sampling the stop bit, then delivering the byte or flagging a framing error
  // BREAK | line held low after a framing error; wait for it to go high
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  localparam logic [11:0] HALF_M1 = 12'(N_CYCLES / 2 - 1);
  localparam logic [11:0] FULL_M1 = 12'(N_CYCLES - 1);

  state_t      state_q, state_d;
  logic        sync_q, rxs_q;
  logic [11:0] n_clks_q, n_clks_d;
  logic [2:0]  n_bits_q, n_bits_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q      <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= S_IDLE;
      n_clks_q    <= '0;
      n_bits_q    <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= rx;
      rxs_q       <= sync_q;
      state_q     <= state_d;
      n_clks_q    <= n_clks_d;
      n_bits_q    <= n_bits_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    n_clks_d    = n_clks_q;
    n_bits_d    = n_bits_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (valid_q && ready) valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d  = S_START;
          n_clks_d = '0;
        end
      end
      S_START: begin
        if (n_clks_q == HALF_M1) begin
          if (!rxs_q) begin
            state_d  = S_DATA;
            n_clks_d = '0;
            n_bits_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          n_clks_d = n_clks_q + 12'd1;
        end
      end
      S_DATA: begin
        if (n_clks_q == FULL_M1) begin
          shift_d[n_bits_q] = rxs_q;
          n_clks_d          = '0;
          n_bits_d          = n_bits_q + 3'd1;
          if (n_bits_q == 3'd7) state_d = S_STOP;
        end else begin
          n_clks_d = n_clks_q + 12'd1;
        end
      end
      S_STOP: begin
        if (n_clks_q == FULL_M1) begin
          n_clks_d = '0;
          if (rxs_q) begin
            // An accept in this same cycle frees the output register for the new byte.
            if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          n_clks_d = n_clks_q + 12'd1;
        end
      end
      S_BREAK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx. It sends directed and random 8N1 frames and checks the deliveries against a queue of expected bytes.
// It also counts frame_err and overrun pulses and compares them with the counts the bench expects.
module tb_uart_rx;

  localparam int N = 16;
  localparam int VALID_LAT = 2 + N / 2 + 9 * N + 1;  // pin edge to valid rising

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, overrun;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [7:0] exp_q[$];
  int n_fe = 0, n_ov = 0, n_acc = 0;
  int exp_fe = 0, exp_ov = 0;
  int t_start = 0, t_valid = -1;
  logic valid_prev = 1'b0;

  uart_rx #(.N_CYCLES(N)) dut (
    .clock(clock), .reset(reset), .rx(rx), .data(data), .valid(valid),
    .ready(ready), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drive one frame. With rdy_pulse set, ready is high only in the stop-sample cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic rdy_pulse);
    logic [9:0] bits;
    bits    = {stop, b, 1'b0};
    t_start = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      for (int j = 0; j < N; j++) begin
        if (rdy_pulse) ready = (i == 9) && (j == N / 2 + 2);
        tick(1);
      end
    end
  endtask

  // Consumer side: every accepted byte must be the oldest one still expected.
  always @(negedge clock) begin
    if (!reset) begin
      if (valid && !valid_prev) t_valid = cyc;
      if (frame_err) n_fe++;
      if (overrun) n_ov++;
      if (frame_err || overrun) chk("fe_ov_exclusive", {31'd0, frame_err & overrun}, 32'd0);
      if (valid && ready) begin
        n_acc++;
        chk("queue_nonempty_on_accept", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) chk("accepted_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
      end
    end
    valid_prev = valid;
  end

  initial begin
    logic [7:0] b;
    logic       stp;
    int         acc0;

    tick(3);
    reset = 1'b0;
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_data", {24'd0, data}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_overrun", {31'd0, overrun}, 32'd0);
    tick(5);

    // Single frame: latency and content.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    chk("a5_valid_latency", t_valid - t_start, VALID_LAT);
    tick(4);
    chk("a5_accepts", n_acc, 1);
    chk("a5_no_fe", n_fe, 0);

    // Start-bit glitch, then a real frame.
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(20);
    chk("glitch_no_valid", {31'd0, valid}, 32'd0);
    chk("glitch_accepts", n_acc, 1);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    tick(4);
    chk("3c_accepts", n_acc, 2);

    // Framing error, held-low line, then recovery.
    send_frame(8'h55, 1'b0, 1'b0);
    exp_fe++;
    tick(40);
    chk("break_no_valid", {31'd0, valid}, 32'd0);
    rx = 1'b1;
    tick(N);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0);
    tick(4);
    chk("fe_count", n_fe, exp_fe);
    chk("81_accepts", n_acc, 3);

    // Overrun with ready held low.
    ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    exp_ov++;
    tick(2);
    chk("ovr_valid_held", {31'd0, valid}, 32'd1);
    chk("ovr_data_kept", {24'd0, data}, 32'h11);
    chk("ovr_count", n_ov, exp_ov);
    ready = 1'b1;
    tick(1);
    chk("ovr_valid_after_accept", {31'd0, valid}, 32'd0);
    chk("ovr_queue_empty", exp_q.size(), 0);

    // Accept lands in the same cycle as the next stop sample.
    ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(8'(k));
      send_frame(8'(k), 1'b1, 1'b1);
    end
    tick(1);
    chk("b2b_last_valid", {31'd0, valid}, 32'd1);
    chk("b2b_last_data", {24'd0, data}, 32'h03);
    ready = 1'b1;
    tick(2);
    chk("b2b_queue_empty", exp_q.size(), 0);
    chk("b2b_no_overrun", n_ov, exp_ov);

    // Reset in the middle of the data bits.
    acc0 = n_acc;
    rx   = 1'b0;
    tick(N * 4);
    reset = 1'b1;
    rx    = 1'b1;
    tick(2);
    reset = 1'b0;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    tick(20);
    chk("rst_no_byte", n_acc, acc0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, 1'b0);
    tick(4);
    chk("0f_accepts", n_acc, acc0 + 1);

    // Random frames, some with a bad stop bit, separated by random idle gaps.
    for (int k = 0; k < 10; k++) begin
      b   = 8'($urandom_range(0, 255));
      stp = ($urandom_range(0, 4) != 0);
      if (stp) exp_q.push_back(b);
      else exp_fe++;
      send_frame(b, stp, 1'b0);
      rx = 1'b1;
      tick($urandom_range(4, 20));
    end
    tick(4);
    chk("rand_queue_empty", exp_q.size(), 0);
    chk("final_fe", n_fe, exp_fe);
    chk("final_ov", n_ov, exp_ov);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
